uart_tx_slave: RTL and testbench

- Memory-mapped UART transmitter that responds on the core's data-memory port, in parallel with the data RAM.
- The core writes bytes into a small TX FIFO.
- A bit-serial state machine shifts each byte out on tx_o as 8N1 at a programmable baud divider.
- A status register and a level interrupt let software poll or wait for FIFO drain.

---
 rtl/uart_tx_slave_if.sv | 19 +
 rtl/uart_tx_slave.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_uart_tx_slave.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_slave_if.sv
// Data-memory port as seen by a memory-mapped peripheral: a registered write
// channel and a combinational read channel.
interface uart_tx_slave_if;
    logic        mem_we_i;
    logic [31:0] mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_raddr_i;
    logic [31:0] mem_rdata_o;

    modport master (
        output mem_we_i, mem_waddr_i, mem_wdata_i, mem_raddr_i,
        input  mem_rdata_o
    );

    modport slave (
        input  mem_we_i, mem_waddr_i, mem_wdata_i, mem_raddr_i,
        output mem_rdata_o
    );
endinterface

// File: rtl/uart_tx_slave.sv
// Memory-mapped UART transmitter: TX FIFO feeding an 8N1 serialiser with a programmable
// baud divider. Define UART_TX_PARITY_EN to add a parity bit (even, or odd via CTRL.ODD).
module uart_tx_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_slave_if.slave bus,
    output logic           tx_o,
    output logic           irq_o
);
    localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_TXDATA = 4'h8;
    localparam logic [3:0] OFF_BAUD   = 4'hC;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    // Register file
    logic        ctrl_en;
    logic        ctrl_odd;
    logic        ctrl_irq_en;
    logic [15:0] baud;
    logic        ovf;

    // FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_req;
    logic             push_ok;
    logic             pop;

    // Serialiser
    state_e      state;
    state_e      state_next;
    logic [15:0] bit_cnt;
    logic [15:0] cnt_next;
    logic [2:0]  bit_idx;
    logic [2:0]  idx_next;
    logic [7:0]  shreg;
    logic [7:0]  shreg_next;
    logic        tx_q;
    logic        tx_next;
    logic        irq_q;
    logic        frame_ready;
    logic        busy;

    // Write decode
    logic wr_sel;
    logic rd_sel;
    logic ctrl_we;
    logic status_we;
    logic baud_we;

    assign wr_sel    = bus.mem_we_i && (bus.mem_waddr_i[31:12] == BASE_ADDR[31:12]);
    assign rd_sel    = bus.mem_raddr_i[31:12] == BASE_ADDR[31:12];
    assign ctrl_we   = wr_sel && (bus.mem_waddr_i[3:0] == OFF_CTRL);
    assign status_we = wr_sel && (bus.mem_waddr_i[3:0] == OFF_STATUS);
    assign push_req  = wr_sel && (bus.mem_waddr_i[3:0] == OFF_TXDATA);
    assign baud_we   = wr_sel && (bus.mem_waddr_i[3:0] == OFF_BAUD);

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            baud        <= DIV_RESET;
        end else begin
            if (ctrl_we) begin
                ctrl_en     <= bus.mem_wdata_i[0];
                ctrl_irq_en <= bus.mem_wdata_i[2];
            end
            if (baud_we) begin
                baud <= bus.mem_wdata_i[15:0];
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par_q;
    logic par_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_odd <= 1'b0;
        end else if (ctrl_we) begin
            ctrl_odd <= bus.mem_wdata_i[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_next;
        end
    end
`else
    assign ctrl_odd = 1'b0;
`endif

    assign fifo_full  = fifo_cnt == CNT_FULL;
    assign fifo_empty = fifo_cnt == '0;
    // A full FIFO still accepts a push when the serialiser frees a slot in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);

    // NOTE: the storage array has no reset; occupancy is tracked by the reset pointers/count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.mem_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: ;
            endcase
            if (push_req && !push_ok) begin
                ovf <= 1'b1;
            end else if (status_we && bus.mem_wdata_i[3]) begin
                ovf <= 1'b0;
            end
        end
    end

    assign frame_ready = ctrl_en && !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_next;
            bit_cnt <= cnt_next;
            bit_idx <= idx_next;
            shreg   <= shreg_next;
            tx_q    <= tx_next;
        end
    end

    // The line level is registered from the next state so tx_o never glitches.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        idx_next   = bit_idx;
        shreg_next = shreg;
        tx_next    = tx_q;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_next   = par_q;
`endif
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                pop     = frame_ready;
            end
            START: begin
                if (bit_cnt == '0) begin
                    state_next = DATA;
                    cnt_next   = baud;
                    idx_next   = '0;
                    tx_next    = shreg[0];
                end else begin
                    cnt_next = bit_cnt - 16'd1;
                end
            end
            DATA: begin
                if (bit_cnt == '0) begin
                    cnt_next = baud;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = par_q;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        idx_next   = bit_idx + 3'd1;
                        shreg_next = {1'b0, shreg[7:1]};
                        tx_next    = shreg[1];
                    end
                end else begin
                    cnt_next = bit_cnt - 16'd1;
                end
            end
            PARITY: begin
                if (bit_cnt == '0) begin
                    state_next = STOP;
                    cnt_next   = baud;
                    tx_next    = 1'b1;
                end else begin
                    cnt_next = bit_cnt - 16'd1;
                end
            end
            STOP: begin
                if (bit_cnt == '0) begin
                    pop = frame_ready;
                    if (!frame_ready) begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    cnt_next = bit_cnt - 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Frame load is shared by IDLE and the end of STOP (back-to-back frames).
        if (pop) begin
            state_next = START;
            cnt_next   = baud;
            shreg_next = fifo_mem[rd_ptr];
            tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_next   = (^fifo_mem[rd_ptr]) ^ ctrl_odd;
`endif
        end
    end

    assign busy = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ctrl_irq_en && fifo_empty && (state == IDLE);
        end
    end

    assign tx_o  = tx_q;
    assign irq_o = irq_q;

    always_comb begin
        bus.mem_rdata_o = '0;
        if (rd_sel) begin
            case (bus.mem_raddr_i[3:0])
                OFF_CTRL:   bus.mem_rdata_o = {29'd0, ctrl_irq_en, ctrl_odd, ctrl_en};
                OFF_STATUS: bus.mem_rdata_o = {28'd0, ovf, fifo_empty, fifo_full, busy};
                OFF_BAUD:   bus.mem_rdata_o = {16'd0, baud};
                default:    ;
            endcase
        end
    end

    // Address and data bits this block never decodes.
    logic unused_bits;
`ifdef UART_TX_PARITY_EN
    assign unused_bits = ^{bus.mem_waddr_i[11:4], bus.mem_raddr_i[11:4], bus.mem_wdata_i[31:16]};
`else
    assign unused_bits = ^{bus.mem_waddr_i[11:4], bus.mem_raddr_i[11:4], bus.mem_wdata_i[31:16],
                           bus.mem_wdata_i[1]};
`endif
endmodule

// File: tb/tb_uart_tx_slave.sv
// Directed bench for uart_tx_slave: expected line levels are queued per byte pushed and
// compared clock by clock as the serialiser drives tx_o.
module tb_uart_tx_slave;
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_TXDATA = BASE + 32'h8;
    localparam logic [31:0] A_BAUD   = BASE + 32'hC;
    localparam int          DEPTH    = 4;

    localparam logic [31:0] ST_BUSY  = 32'h1;
    localparam logic [31:0] ST_FULL  = 32'h2;
    localparam logic [31:0] ST_EMPTY = 32'h4;
    localparam logic [31:0] ST_OVF   = 32'h8;

`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
    localparam logic [31:0] CTRL_ALL   = 32'h7;
`else
    localparam int          FRAME_BITS = 10;
    localparam logic [31:0] CTRL_ALL   = 32'h5;
`endif

    logic clk;
    logic rst;
    logic tx_o;
    logic irq_o;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    uart_tx_slave_if bus ();

    uart_tx_slave #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH),
        .DIV_RESET (16'd433)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .tx_o (tx_o),
        .irq_o(irq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.mem_we_i    = 1'b1;
        bus.mem_waddr_i = a;
        bus.mem_wdata_i = d;
        @(negedge clk);
        bus.mem_we_i    = 1'b0;
    endtask

    // Read without consuming a clock; used where cycle position matters.
    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.mem_raddr_i = a;
        #1;
        check(tag, bus.mem_rdata_o, exp);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        peek(tag, a, exp);
    endtask

    function automatic void push_frame(input logic [7:0] b, input bit odd);
        bit par;
        par = (^b) ^ odd;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(par);
`endif
        exp_q.push_back(1'b1);
    endfunction

    task automatic send(input logic [31:0] d, input bit odd, input bit accepted);
        wr(A_TXDATA, d);
        if (accepted) push_frame(d[7:0], odd);
    endtask

    // Each expected level must hold for exactly baud+1 clocks, frames back to back.
    task automatic check_frames(input int n, input int baud);
        int waited;
        waited = 0;
        while (tx_o !== 1'b0 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("frame_start", {31'd0, tx_o}, 32'd0);
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < FRAME_BITS; b++) begin
                bit e;
                e = exp_q.pop_front();
                for (int c = 0; c <= baud; c++) begin
                    check($sformatf("frame%0d_bit%0d_clk%0d", f, b, c), {31'd0, tx_o}, {31'd0, e});
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        int waited;
        rst             = 1'b1;
        bus.mem_we_i    = 1'b0;
        bus.mem_waddr_i = '0;
        bus.mem_wdata_i = '0;
        bus.mem_raddr_i = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx_o}, 32'd1);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        rst = 1'b0;

        // Reset defaults
        rd_check("rst_status", A_STATUS, ST_EMPTY);
        rd_check("rst_baud", A_BAUD, 32'd433);
        rd_check("rst_ctrl", A_CTRL, 32'd0);

        // Decode: unselected/hole writes ignored, unused bits read 0
        wr(32'h4000_000C, 32'd5);
        rd_check("unsel_wr", A_BAUD, 32'd433);
        rd_check("unsel_rd", 32'h3000_100C, 32'd0);
        wr(BASE + 32'h1, 32'hFFFF_FFFF);
        rd_check("hole_wr", A_CTRL, 32'd0);
        rd_check("hole_rd", BASE + 32'h1, 32'd0);
        rd_check("txdata_rd", A_TXDATA, 32'd0);
        wr(A_CTRL, 32'hFFFF_FFFF);
        rd_check("ctrl_rw", A_CTRL, CTRL_ALL);
        wr(A_CTRL, 32'd0);
        wr(A_BAUD, 32'hABCD_1234);
        rd_check("baud_rw", A_BAUD, 32'h0000_1234);

        // Single byte, BAUD=3; upper write-data bits ignored
        wr(A_BAUD, 32'd3);
        wr(A_CTRL, 32'd1);
        send(32'h1234_56A5, 1'b0, 1'b1);
        check("lat_n1_high", {31'd0, tx_o}, 32'd1);
        @(negedge clk);
        check("lat_n2_low", {31'd0, tx_o}, 32'd0);
        check_frames(1, 3);
        check("single_idle", {31'd0, tx_o}, 32'd1);
        rd_check("single_status", A_STATUS, ST_EMPTY);
        check("irq_disabled", {31'd0, irq_o}, 32'd0);

        // Back-to-back frames, BAUD=1
        wr(A_CTRL, 32'd0);
        wr(A_BAUD, 32'd1);
        send(32'h3C, 1'b0, 1'b1);
        send(32'h81, 1'b0, 1'b1);
        send(32'hF0, 1'b0, 1'b1);
        rd_check("queued_status", A_STATUS, ST_BUSY);
        wr(A_CTRL, 32'd1);
        check_frames(3, 1);
        check("b2b_idle", {31'd0, tx_o}, 32'd1);
        rd_check("b2b_status", A_STATUS, ST_EMPTY);

        // EN cleared mid-frame: frame completes, next byte stays queued
        wr(A_CTRL, 32'd0);
        send(32'h55, 1'b0, 1'b1);
        send(32'hC3, 1'b0, 1'b1);
        wr(A_CTRL, 32'd1);
        fork
            check_frames(1, 1);
            begin
                repeat (6) @(negedge clk);
                wr(A_CTRL, 32'd0);
            end
        join
        for (int i = 0; i < 8; i++) begin
            check("en_off_idle", {31'd0, tx_o}, 32'd1);
            @(negedge clk);
        end
        rd_check("en_off_status", A_STATUS, ST_BUSY);
        wr(A_CTRL, 32'd1);
        check_frames(1, 1);
        rd_check("en_on_status", A_STATUS, ST_EMPTY);

        // Overflow with EN=0, then push+pop while full, BAUD=0
        wr(A_CTRL, 32'd0);
        wr(A_BAUD, 32'd0);
        for (int i = 0; i < DEPTH; i++) send(32'h11 * (i + 1), 1'b0, 1'b1);
        send(32'h99, 1'b0, 1'b0);
        rd_check("ovf_status", A_STATUS, ST_BUSY | ST_FULL | ST_OVF);
        wr(A_STATUS, 32'h0);
        rd_check("ovf_sticky", A_STATUS, ST_BUSY | ST_FULL | ST_OVF);
        wr(A_STATUS, 32'h8);
        rd_check("ovf_clear", A_STATUS, ST_BUSY | ST_FULL);
        @(negedge clk);
        bus.mem_we_i    = 1'b1;
        bus.mem_waddr_i = A_CTRL;
        bus.mem_wdata_i = 32'd1;
        @(negedge clk);
        bus.mem_waddr_i = A_TXDATA;
        bus.mem_wdata_i = 32'h66;
        @(negedge clk);
        bus.mem_we_i    = 1'b0;
        push_frame(8'h66, 1'b0);
        peek("push_pop_full", A_STATUS, ST_BUSY | ST_FULL);
        check_frames(DEPTH + 1, 0);
        rd_check("drain_status", A_STATUS, ST_EMPTY);

        // Interrupt after the stop bit
        wr(A_CTRL, 32'd0);
        wr(A_BAUD, 32'd1);
        send(32'h5A, 1'b0, 1'b1);
        wr(A_CTRL, 32'h5);
        check("irq_during", {31'd0, irq_o}, 32'd0);
        check_frames(1, 1);
        check("irq_pre", {31'd0, irq_o}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq_o}, 32'd1);

        // Asynchronous reset during DATA
        wr(A_BAUD, 32'd3);
        send(32'h00, 1'b0, 1'b0);
        waited = 0;
        while (tx_o !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        check("pre_rst_data", {31'd0, tx_o}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_async_tx", {31'd0, tx_o}, 32'd1);
        check("rst_async_irq", {31'd0, irq_o}, 32'd0);
        peek("rst_async_status", A_STATUS, ST_EMPTY);
        peek("rst_async_baud", A_BAUD, 32'd433);
        peek("rst_async_ctrl", A_CTRL, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_tx", {31'd0, tx_o}, 32'd1);
        rd_check("post_rst_status", A_STATUS, ST_EMPTY);

        // Parity byte (11-bit frame when parity is built in)
        wr(A_BAUD, 32'd1);
        wr(A_CTRL, 32'd1);
        send(32'h07, 1'b0, 1'b1);
        check_frames(1, 1);
        wr(A_CTRL, 32'd3);
        send(32'h07, 1'b1, 1'b1);
        check_frames(1, 1);
        check("par_idle", {31'd0, tx_o}, 32'd1);
        rd_check("par_status", A_STATUS, ST_EMPTY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
